// File: rtl/vga_pkg.sv
// Shared VGA timing constants and coordinate type for the raster generator.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX counter with a combinational terminal-count flag.
module wrap_counter
    import vga_pkg::*;
#(
    parameter int MAX = 800
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    output logic [COORD_W-1:0] count,
    output logic               wrap
);

    coord_t r_count;

    assign wrap  = (r_count == coord_t'(MAX - 1));
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_count <= '0;
        else if (en)
            r_count <= wrap ? '0 : r_count + 1'b1;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clk/2 pixel clock, x/y position, registered sync/blank and
// a frame-start pulse.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               pixel_clk,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic               sync,
    output logic [COORD_W-1:0] draw_x,
    output logic [COORD_W-1:0] draw_y,
    output logic               frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    generate
        if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_size_chk
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
        end
    endgenerate

    logic   r_pixel_clk, r_hs, r_vs, r_blank, r_frame_start;
    logic   w_adv, w_hwrap, w_vwrap, w_ven;
    coord_t w_x, w_y, w_x_nxt, w_y_nxt;

    // A pixel advances on the edge where pixel_clk is high and about to fall.
    assign w_adv = r_pixel_clk;
    assign w_ven = w_adv & w_hwrap;

    wrap_counter #(.MAX(H_TOTAL)) u_hcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_adv),
        .count   (w_x),
        .wrap    (w_hwrap)
    );

    wrap_counter #(.MAX(V_TOTAL)) u_vcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_ven),
        .count   (w_y),
        .wrap    (w_vwrap)
    );

    // Decode from the post-edge position so sync/blank line up with draw_x/draw_y.
    assign w_x_nxt = !w_adv ? w_x : (w_hwrap ? '0 : w_x + 1'b1);
    assign w_y_nxt = !w_ven ? w_y : (w_vwrap ? '0 : w_y + 1'b1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pixel_clk   <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_pixel_clk   <= ~r_pixel_clk;
            r_hs          <= !((int'(w_x_nxt) >= HS_START) && (int'(w_x_nxt) < HS_END));
            r_vs          <= !((int'(w_y_nxt) >= VS_START) && (int'(w_y_nxt) < VS_END));
            r_blank       <= (int'(w_x_nxt) < H_VISIBLE) && (int'(w_y_nxt) < V_VISIBLE);
            r_frame_start <= w_ven & w_vwrap;
        end
    end

    assign pixel_clk   = r_pixel_clk;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign sync        = 1'b0;
    assign draw_x      = w_x;
    assign draw_y      = w_y;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing plus a tiny override, with
// random resets, checked every clk against a closed-form position model.
module tb_vga_timing_gen;

    logic       clk;
    logic       rn_d, rn_s;
    logic       pclk_d, hs_d, vs_d, bl_d, sy_d, fs_d;
    logic       pclk_s, hs_s, vs_s, bl_s, sy_s, fs_s;
    logic [9:0] x_d, y_d, x_s, y_s;

    int n_chk = 0;
    int n_err = 0;

    vga_timing_gen dut_d (
        .clk(clk), .reset_n(rn_d), .pixel_clk(pclk_d), .hs(hs_d), .vs(vs_d),
        .blank(bl_d), .sync(sy_d), .draw_x(x_d), .draw_y(y_d), .frame_start(fs_d)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_s (
        .clk(clk), .reset_n(rn_s), .pixel_clk(pclk_s), .hs(hs_s), .vs(vs_s),
        .blank(bl_s), .sync(sy_s), .draw_x(x_s), .draw_y(y_s), .frame_start(fs_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // k = clk edges since the last reset edge; the pixel index is k/2 and the
    // raster position follows by plain division.
    function automatic logic [25:0] ref_vec(input int k, input int hv, input int hf,
                                            input int hsw, input int hb, input int vv,
                                            input int vf, input int vsw, input int vb);
        int  ht, vt, n, x, y;
        logic e_hs, e_vs, e_bl, e_fs;
        ht   = hv + hf + hsw + hb;
        vt   = vv + vf + vsw + vb;
        n    = k / 2;
        x    = n % ht;
        y    = (n / ht) % vt;
        e_hs = !((x >= hv + hf) && (x < hv + hf + hsw));
        e_vs = !((y >= vv + vf) && (y < vv + vf + vsw));
        e_bl = (x < hv) && (y < vv);
        e_fs = (k > 0) && (k % 2 == 0) && (n % (ht * vt) == 0);
        return {1'(k % 2), e_hs, e_vs, e_bl, 1'b0, e_fs, 10'(x), 10'(y)};
    endfunction

    localparam int NCYC = 40000;
    localparam int MRST = 2 * (800 * 12 + 300);

    initial begin
        int  kd, ks, hs_low, last_fs;
        bit  mid_done, first_line;
        kd = 0; ks = 0; hs_low = 0; last_fs = -1;
        mid_done = 0; first_line = 1;
        rn_d = 1'b0;
        rn_s = 1'b0;
        @(posedge clk);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            chk("dflt", {pclk_d, hs_d, vs_d, bl_d, sy_d, fs_d, x_d, y_d},
                ref_vec(kd, 640, 16, 96, 48, 480, 10, 2, 33));
            chk("small", {pclk_s, hs_s, vs_s, bl_s, sy_s, fs_s, x_s, y_s},
                ref_vec(ks, 8, 1, 2, 1, 4, 1, 1, 1));

            if (first_line && cyc >= 5) begin
                if (kd < 1600) begin
                    if (!hs_d) hs_low++;
                end else begin
                    chk("line1_hs_low_clks", hs_low, 192);
                    chk("line1_xy", {x_d, y_d}, {10'd0, 10'd1});
                    first_line = 0;
                end
            end

            if (fs_s === 1'b1) begin
                if (last_fs >= 0) chk("small_fs_period", cyc - last_fs, 168);
                last_fs = cyc;
            end

            if (cyc < 5) begin
                rn_d = 1'b0;
                rn_s = 1'b0;
            end else begin
                rn_d = !(kd == MRST && !mid_done);
                if (!rn_d) mid_done = 1;
                rn_s = ($urandom_range(0, 599) != 0);
            end
            if (!rn_s) last_fs = -1;
            kd = rn_d ? kd + 1 : 0;
            ks = rn_s ? ks + 1 : 0;
        end
        chk("mid_reset_done", 64'(mid_done), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
